// File: rtl/perf_counter_controller_pkg.sv
// Shared widths, register map and types for the event-counter controller.
// Imported by the counter slice and the top level.
package perf_pkg;

    localparam int PRFC_WIDTH = 48;

    typedef logic [PRFC_WIDTH-1:0] prfc_value_t;

    localparam logic [5:0] CR_EVENT_SEL_BASE = 6'h00;
    localparam logic [5:0] CR_COUNT_LO_BASE  = 6'h10;
    localparam logic [5:0] CR_COUNT_HI_BASE  = 6'h20;
    localparam logic [5:0] CR_CTRL           = 6'h30;
    localparam logic [5:0] CR_OVF_STATUS     = 6'h31;

endpackage

// File: rtl/perf_counter_controller_if.sv
// Control-register port: strobed read/write requests and registered read return.
// The CR unit is the master; the counter controller is the slave.
interface perf_counter_controller_if;
    logic        cr_write_en;
    logic        cr_read_en;
    logic [5:0]  cr_addr;
    logic [31:0] cr_write_data;
    logic [31:0] cr_read_data;
    logic        cr_read_valid;

    modport master (
        output cr_write_en, cr_read_en, cr_addr, cr_write_data,
        input  cr_read_data, cr_read_valid
    );

    modport slave (
        input  cr_write_en, cr_read_en, cr_addr, cr_write_data,
        output cr_read_data, cr_read_valid
    );
endinterface

// File: rtl/perf_event_counter.sv
// One 48-bit counter slice: event select register, event mux, increment with clear priority, wrap detect.
// Latency: increment visible the edge after the selected event; wrap_o is combinational for that edge.
// Backpressure: none, every event pulse is counted.
module perf_event_counter
    import perf_pkg::*;
#(
    parameter int NUM_EVENTS = 16,
    parameter int SEL_W      = $clog2(NUM_EVENTS)
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  en_i,
    input  logic [NUM_EVENTS-1:0] event_i,
    input  logic                  sel_we_i,
    input  logic [31:0]           sel_wdata_i,
    input  logic                  clr_i,
    output logic [SEL_W-1:0]      sel_o,
    output prfc_value_t           count_o,
    output logic                  wrap_o
);

    logic [SEL_W-1:0] sel_q, sel_d;
    logic             sel_ok_q, sel_ok_d;
    prfc_value_t      count_q, count_d;
    logic             inc;

    // The full write value is range-checked so selects >= NUM_EVENTS never count,
    // even when they alias an in-range value in the stored SEL_W bits.
    always_comb begin
        sel_d    = sel_q;
        sel_ok_d = sel_ok_q;
        if (sel_we_i) begin
            sel_d    = sel_wdata_i[SEL_W-1:0];
            sel_ok_d = (sel_wdata_i < 32'(NUM_EVENTS));
        end
    end

    assign inc = en_i && sel_ok_q && event_i[sel_q];

    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (inc) begin
            count_d = count_q + prfc_value_t'(1);
        end
    end

    assign wrap_o  = inc && !clr_i && (&count_q);
    assign sel_o   = sel_q;
    assign count_o = count_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sel_q    <= '0;
            sel_ok_q <= 1'b1;
            count_q  <= '0;
        end else begin
            sel_q    <= sel_d;
            sel_ok_q <= sel_ok_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/perf_counter_controller.sv
// Perf-counter controller: CR decode, CTRL, shadow-high, read pipeline; PERF_OVERFLOW_INT_EN adds OVF_STATUS + irq.
// Latency: reads return one cycle after cr_read_en; counters update the edge after an event.
// Backpressure: none, reads and writes are accepted every cycle.
module perf_counter_controller
    import perf_pkg::*;
#(
    parameter int NUM_EVENTS   = 16,
    parameter int NUM_COUNTERS = 4
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [NUM_EVENTS-1:0]   perf_event,
    perf_counter_controller_if.slave cr,
    output logic                    perf_overflow_int
);

    localparam int SEL_W = $clog2(NUM_EVENTS);

    logic [SEL_W-1:0]        sel   [NUM_COUNTERS];
    prfc_value_t             count [NUM_COUNTERS];
    logic [NUM_COUNTERS-1:0] wrap;
    logic [NUM_COUNTERS-1:0] sel_we;
    logic [NUM_COUNTERS-1:0] cnt_clr;

    logic        ctrl_en_q, ctrl_en_d;
    logic [15:0] shadow_hi_q, shadow_hi_d;
    logic        rd_vld_q;
    logic [31:0] rd_dat_q, rd_dat_d;
    logic        wr_ctrl, clr_all;

    assign wr_ctrl   = cr.cr_write_en && (cr.cr_addr == CR_CTRL);
    assign clr_all   = wr_ctrl && cr.cr_write_data[1];
    assign ctrl_en_d = wr_ctrl ? cr.cr_write_data[0] : ctrl_en_q;

    for (genvar i = 0; i < NUM_COUNTERS; i++) begin : g_cnt
        assign sel_we[i]  = cr.cr_write_en && (cr.cr_addr == CR_EVENT_SEL_BASE + 6'(i));
        assign cnt_clr[i] = clr_all || (cr.cr_write_en &&
                            ((cr.cr_addr == CR_COUNT_LO_BASE + 6'(i)) ||
                             (cr.cr_addr == CR_COUNT_HI_BASE + 6'(i))));

        perf_event_counter #(
            .NUM_EVENTS (NUM_EVENTS),
            .SEL_W      (SEL_W)
        ) u_cnt (
            .clk         (clk),
            .reset_n     (reset_n),
            .en_i        (ctrl_en_q),
            .event_i     (perf_event),
            .sel_we_i    (sel_we[i]),
            .sel_wdata_i (cr.cr_write_data),
            .clr_i       (cnt_clr[i]),
            .sel_o       (sel[i]),
            .count_o     (count[i]),
            .wrap_o      (wrap[i])
        );
    end

`ifdef PERF_OVERFLOW_INT_EN
    logic [NUM_COUNTERS-1:0] ovf_q, ovf_d;
    logic                    ovf_int_q;

    // A wrap in the same cycle as a write-1-clear keeps the bit set.
    always_comb begin
        ovf_d = ovf_q;
        if (cr.cr_write_en && (cr.cr_addr == CR_OVF_STATUS)) begin
            ovf_d = ovf_q & ~cr.cr_write_data[NUM_COUNTERS-1:0];
        end
        ovf_d = ovf_d | wrap;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ovf_q     <= '0;
            ovf_int_q <= 1'b0;
        end else begin
            ovf_q     <= ovf_d;
            ovf_int_q <= |ovf_q;
        end
    end

    assign perf_overflow_int = ovf_int_q;
`else
    wire unused_wrap = |wrap;

    assign perf_overflow_int = 1'b0;
`endif

    // Read mux sees pre-edge state, so a read paired with a write or an increment returns the old value.
    always_comb begin
        rd_dat_d    = '0;
        shadow_hi_d = shadow_hi_q;
        for (int i = 0; i < NUM_COUNTERS; i++) begin
            if (cr.cr_addr == CR_EVENT_SEL_BASE + 6'(i)) begin
                rd_dat_d = 32'(sel[i]);
            end
            if (cr.cr_addr == CR_COUNT_LO_BASE + 6'(i)) begin
                rd_dat_d = count[i][31:0];
                if (cr.cr_read_en) begin
                    shadow_hi_d = count[i][47:32];
                end
            end
            if (cr.cr_addr == CR_COUNT_HI_BASE + 6'(i)) begin
                rd_dat_d = {16'h0000, shadow_hi_q};
            end
        end
        if (cr.cr_addr == CR_CTRL) begin
            rd_dat_d = {31'h0, ctrl_en_q};
        end
`ifdef PERF_OVERFLOW_INT_EN
        if (cr.cr_addr == CR_OVF_STATUS) begin
            rd_dat_d = 32'(ovf_q);
        end
`endif
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ctrl_en_q   <= 1'b0;
            shadow_hi_q <= '0;
            rd_vld_q    <= 1'b0;
            rd_dat_q    <= '0;
        end else begin
            ctrl_en_q   <= ctrl_en_d;
            shadow_hi_q <= shadow_hi_d;
            rd_vld_q    <= cr.cr_read_en;
            if (cr.cr_read_en) begin
                rd_dat_q <= rd_dat_d;
            end
        end
    end

    assign cr.cr_read_valid = rd_vld_q;
    assign cr.cr_read_data  = rd_dat_q;

endmodule

// File: tb/tb_perf_counter_controller.sv
// Directed bench for perf_counter_controller: hand-computed register readbacks and interrupt timing.
module tb_perf_counter_controller;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [15:0] perf_event = '0;
    logic        perf_overflow_int;
    int          n_cmp = 0;
    int          n_err = 0;

    perf_counter_controller_if cr_if ();

    perf_counter_controller #(
        .NUM_EVENTS   (16),
        .NUM_COUNTERS (4)
    ) dut (
        .clk               (clk),
        .reset_n           (reset_n),
        .perf_event        (perf_event),
        .cr                (cr_if),
        .perf_overflow_int (perf_overflow_int)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [5:0] a, input logic [31:0] d);
        @(negedge clk);
        cr_if.cr_write_en   = 1'b1;
        cr_if.cr_addr       = a;
        cr_if.cr_write_data = d;
        @(negedge clk);
        cr_if.cr_write_en   = 1'b0;
    endtask

    // Valid must be high exactly on the cycle after the strobe.
    task automatic rd(input logic [5:0] a, input logic [31:0] exp, input string tag);
        @(negedge clk);
        cr_if.cr_read_en = 1'b1;
        cr_if.cr_addr    = a;
        @(negedge clk);
        cr_if.cr_read_en = 1'b0;
        check({tag, "_vld"}, 64'(cr_if.cr_read_valid), 64'd1);
        check(tag, 64'(cr_if.cr_read_data), 64'(exp));
        @(negedge clk);
        check({tag, "_vld_drop"}, 64'(cr_if.cr_read_valid), 64'd0);
    endtask

    task automatic pulse(input logic [15:0] mask, input logic [15:0] base, input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            perf_event = mask;
        end
        @(negedge clk);
        perf_event = base;
    endtask

    initial begin
        cr_if.cr_write_en   = 1'b0;
        cr_if.cr_read_en    = 1'b0;
        cr_if.cr_addr       = '0;
        cr_if.cr_write_data = '0;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_vld", 64'(cr_if.cr_read_valid), 64'd0);
        check("rst_dat", 64'(cr_if.cr_read_data), 64'd0);
        check("rst_int", 64'(perf_overflow_int), 64'd0);
        reset_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            rd(6'(i), 32'h0, "rst_sel");
            rd(6'h10 + 6'(i), 32'h0, "rst_lo");
            rd(6'h20 + 6'(i), 32'h0, "rst_hi");
        end
        rd(6'h30, 32'h0, "rst_ctrl");
        rd(6'h31, 32'h0, "rst_ovf");

        // Basic counting: counter 0 on event 3, event 2 held high as noise
        wr(6'h00, 32'd3);
        wr(6'h30, 32'h1);
        rd(6'h00, 32'd3, "sel0_rb");
        rd(6'h30, 32'h1, "ctrl_rb");
        perf_event = 16'h0004;
        pulse(16'h000C, 16'h0004, 10);
        perf_event = 16'h0000;
        rd(6'h10, 32'd10, "cnt0_lo10");
        rd(6'h20, 32'd0, "cnt0_hi10");
        rd(6'h11, 32'd0, "cnt1_lo0");

        // Carry into the high half; shadow-high stays frozen until the next LO read
        @(negedge clk);
        force dut.g_cnt[0].u_cnt.count_q = 48'h0000_FFFF_FFFF;
        @(negedge clk);
        release dut.g_cnt[0].u_cnt.count_q;
        pulse(16'h0008, 16'h0000, 1);
        rd(6'h10, 32'h0, "carry_lo");
        rd(6'h20, 32'h1, "carry_hi");
        pulse(16'h0008, 16'h0000, 5);
        rd(6'h20, 32'h1, "shadow_hold");
        rd(6'h10, 32'h5, "carry_lo5");

        // Read and clearing write in the same cycle: read sees the old value
        @(negedge clk);
        cr_if.cr_read_en    = 1'b1;
        cr_if.cr_write_en   = 1'b1;
        cr_if.cr_addr       = 6'h10;
        cr_if.cr_write_data = 32'hDEAD_BEEF;
        @(negedge clk);
        cr_if.cr_read_en  = 1'b0;
        cr_if.cr_write_en = 1'b0;
        check("rdwr_vld", 64'(cr_if.cr_read_valid), 64'd1);
        check("rdwr_old", 64'(cr_if.cr_read_data), 64'd5);
        rd(6'h10, 32'h0, "wrclr_lo");
        rd(6'h20, 32'h0, "wrclr_hi");

        // Clear-all wins over a same-cycle event
        wr(6'h01, 32'd5);
        pulse(16'h0028, 16'h0000, 3);
        rd(6'h11, 32'd3, "cnt1_lo3");
        @(negedge clk);
        perf_event          = 16'h0028;
        cr_if.cr_write_en   = 1'b1;
        cr_if.cr_addr       = 6'h30;
        cr_if.cr_write_data = 32'h2;
        @(negedge clk);
        perf_event        = 16'h0000;
        cr_if.cr_write_en = 1'b0;
        rd(6'h10, 32'h0, "clrall_c0");
        rd(6'h11, 32'h0, "clrall_c1");
        rd(6'h30, 32'h0, "clrall_ctrl");

        // Out-of-range select never counts; in-range slices count 20
        wr(6'h30, 32'h1);
        wr(6'h02, 32'd16);
        pulse(16'hFFFF, 16'h0000, 20);
        rd(6'h12, 32'd0, "oor_c2");
        rd(6'h13, 32'd20, "all_c3");
        rd(6'h10, 32'd20, "all_c0");

        // Unmapped and out-of-range indices
        wr(6'h04, 32'd7);
        wr(6'h14, 32'd0);
        rd(6'h04, 32'h0, "unmap_sel4");
        rd(6'h14, 32'h0, "unmap_lo4");
        rd(6'h24, 32'h0, "unmap_hi4");
        rd(6'h3F, 32'h0, "unmap_3f");
        rd(6'h13, 32'd20, "unmap_nowr");

        // Counter 1 wraps from all-ones
        @(negedge clk);
        force dut.g_cnt[1].u_cnt.count_q = 48'hFFFF_FFFF_FFFF;
        @(negedge clk);
        release dut.g_cnt[1].u_cnt.count_q;
        @(negedge clk);
        perf_event = 16'h0020;
        @(negedge clk);
        perf_event = 16'h0000;
        check("int_lag", 64'(perf_overflow_int), 64'd0);
        @(negedge clk);
`ifdef PERF_OVERFLOW_INT_EN
        check("int_set", 64'(perf_overflow_int), 64'd1);
        rd(6'h31, 32'h2, "ovf_status");
`else
        check("int_tied", 64'(perf_overflow_int), 64'd0);
        rd(6'h31, 32'h0, "ovf_absent");
`endif
        rd(6'h11, 32'h0, "wrap_lo");
        rd(6'h21, 32'h0, "wrap_hi");
        wr(6'h31, 32'h2);
        @(negedge clk);
        check("int_clear", 64'(perf_overflow_int), 64'd0);
        rd(6'h31, 32'h0, "ovf_cleared");

        // Reset in the middle of a read return
        @(negedge clk);
        cr_if.cr_read_en = 1'b1;
        cr_if.cr_addr    = 6'h13;
        @(negedge clk);
        cr_if.cr_read_en = 1'b0;
        check("midrd_vld", 64'(cr_if.cr_read_valid), 64'd1);
        check("midrd_dat", 64'(cr_if.cr_read_data), 64'd20);
        reset_n = 1'b0;
        #1;
        check("midrd_rst_vld", 64'(cr_if.cr_read_valid), 64'd0);
        check("midrd_rst_dat", 64'(cr_if.cr_read_data), 64'd0);
        @(negedge clk);
        reset_n = 1'b1;
        rd(6'h13, 32'h0, "post_rst_c3");
        rd(6'h30, 32'h0, "post_rst_ctrl");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
